// File: rtl/memory_arbiter_if.sv
// Request/RAM bus between the MIPS datapath, the shared RAM model and memory_arbiter.
// Handshake: a requester raises iREN or dREN/dWEN and holds its address and store data steady until its wait drops for one cycle; that cycle carries the load data.
interface memory_arbiter_if #(
  parameter int WORD_W = 32
);
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              iwait;
  logic              dwait;
  logic [WORD_W-1:0] iload;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              memerr;

  // arbiter side
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  // datapath + RAM side
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data access; data wins ties.
// Define ARB_FAIRNESS_EN to force a fetch grant after STARVE_LIMIT data grants.
module memory_arbiter #(
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                CLK,
  input  logic                RST,
  memory_arbiter_if.slave     bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, DSERV = 2'd1, ISERV = 2'd2} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  // The counter is 0 on the first service cycle, so the last allowed cycle sees TIMEOUT_CYCLES-1.
  localparam logic [7:0] TOUT_LAST  = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, next_state;
  logic [7:0] tcount;
  logic       memerr_q;
  logic       err_set;
  logic       d_req, ack, err, tout;
  logic       starve_hit;

  assign d_req = bus.dREN | bus.dWEN;
  assign ack   = (bus.ramstate == RAM_ACCESS);
  assign err   = (bus.ramstate == RAM_ERROR);
  assign tout  = (tcount == TOUT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      tcount   <= '0;
      memerr_q <= 1'b0;
    end else begin
      state    <= next_state;
      tcount   <= (state == IDLE) ? 8'd0 : tcount + 8'd1;
      memerr_q <= memerr_q | err_set;
    end
  end

`ifdef ARB_FAIRNESS_EN
  logic [7:0] starve;

  assign starve_hit = (starve == 8'(STARVE_LIMIT)) && bus.iREN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve <= '0;
    end else if (state == IDLE) begin
      if (!bus.iREN || next_state == ISERV) starve <= '0;
      else if (next_state == DSERV)         starve <= starve + 8'd1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    next_state   = state;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        if (starve_hit)    next_state = ISERV;
        else if (d_req)    next_state = DSERV;
        else if (bus.iREN) next_state = ISERV;
      end
      DSERV: begin
        // A withdrawn request releases the RAM without signalling completion.
        if (!d_req) begin
          next_state = IDLE;
        end else begin
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = !bus.dWEN;
          if (ack || err) begin
            bus.dwait  = 1'b0;
            if (!bus.dWEN) bus.dload = bus.ramload;
            err_set    = err;
            next_state = IDLE;
          end else if (tout) begin
            bus.dwait  = 1'b0;
            err_set    = 1'b1;
            next_state = IDLE;
          end
        end
      end
      ISERV: begin
        if (!bus.iREN) begin
          next_state = IDLE;
        end else begin
          bus.ramaddr = bus.iaddr;
          bus.ramREN  = 1'b1;
          if (ack || err) begin
            bus.iwait  = 1'b0;
            bus.iload  = bus.ramload;
            err_set    = err;
            next_state = IDLE;
          end else if (tout) begin
            bus.iwait  = 1'b0;
            err_set    = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.memerr = memerr_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed vector bench for memory_arbiter: a table of per-cycle inputs and expected outputs,
// plus hand-built timeout and (with ARB_FAIRNESS_EN) starvation sequences.
module tb_memory_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;
  localparam logic [1:0] S_IDLE = 2'd0, S_DSERV = 2'd1, S_ISERV = 2'd2;

  typedef struct {
    string       name;
    logic        rst, iren;
    logic [31:0] iaddr;
    logic        dren, dwen;
    logic [31:0] daddr, dstore;
    logic [1:0]  rstate;
    logic [31:0] rload;
    logic [1:0]  e_state;
    logic        e_iwait, e_dwait;
    logic [31:0] e_iload, e_dload;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    logic        e_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;
  int         vectors_applied = 0;
  int         miscompares = 0;
  vec_t       tbl[$];

  memory_arbiter_if #(.WORD_W(32)) bus ();

  memory_arbiter #(.WORD_W(32), .TIMEOUT_CYCLES(8), .STARVE_LIMIT(2)) dut (
    .CLK(clk), .RST(rst), .bus(bus.slave), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input string nm, input logic r, input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] ds,
    input logic [1:0] rs, input logic [31:0] rl,
    input logic [1:0] st, input logic iw, input logic dwt, input logic [31:0] il,
    input logic [31:0] dl, input logic re, input logic we, input logic [31:0] ad,
    input logic [31:0] sd, input logic er);
    vec_t v;
    v.name = nm; v.rst = r; v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw;
    v.daddr = da; v.dstore = ds; v.rstate = rs; v.rload = rl;
    v.e_state = st; v.e_iwait = iw; v.e_dwait = dwt; v.e_iload = il; v.e_dload = dl;
    v.e_ren = re; v.e_wen = we; v.e_addr = ad; v.e_store = sd; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string vn, input string field, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s: got %h, expected %h", vn, field, act, exp);
    end
  endtask

  // Drive at the falling edge, check combinational outputs 1 ns later, before the rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; bus.iREN = v.iren; bus.iaddr = v.iaddr; bus.dREN = v.dren; bus.dWEN = v.dwen;
    bus.daddr = v.daddr; bus.dstore = v.dstore; bus.ramstate = v.rstate; bus.ramload = v.rload;
    #1;
    vectors_applied++;
    chk(v.name, "state",    32'(state_dbg),    32'(v.e_state));
    chk(v.name, "iwait",    32'(bus.iwait),    32'(v.e_iwait));
    chk(v.name, "dwait",    32'(bus.dwait),    32'(v.e_dwait));
    chk(v.name, "iload",    bus.iload,         v.e_iload);
    chk(v.name, "dload",    bus.dload,         v.e_dload);
    chk(v.name, "ramREN",   32'(bus.ramREN),   32'(v.e_ren));
    chk(v.name, "ramWEN",   32'(bus.ramWEN),   32'(v.e_wen));
    chk(v.name, "ramaddr",  bus.ramaddr,       v.e_addr);
    chk(v.name, "ramstore", bus.ramstore,      v.e_store);
    chk(v.name, "memerr",   32'(bus.memerr),   32'(v.e_err));
  endtask

  task automatic idle_vec(input string nm, input logic r, input logic err_exp);
    apply(mk(nm, r, 0, 0, 0, 0, 0, 0, FREE, 0, S_IDLE, 1, 1, 0, 0, 0, 0, 0, 0, err_exp));
  endtask

  initial begin
    rst = 1'b1;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = FREE;
    repeat (2) @(posedge clk);

    //                 name        rst ir iaddr dr dw daddr  dstore        rs    rload          st      iw dw iload         dload         re we addr   store         er
    tbl.push_back(mk("reset",     1, 0, 0,    0, 0, 0,     0,            FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("f_idle",    0, 1, 'h40, 0, 0, 0,     0,            FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("f_busy",    0, 1, 'h40, 0, 0, 0,     0,            BUSY, 0,             S_ISERV,1, 1, 0,            0,            1, 0, 'h40,  0,            0));
    tbl.push_back(mk("f_acc",     0, 1, 'h40, 0, 0, 0,     0,            ACC,  'h8C010004,    S_ISERV,0, 1, 'h8C010004,   0,            1, 0, 'h40,  0,            0));
    tbl.push_back(mk("f_done",    0, 0, 'h40, 0, 0, 0,     0,            FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("c_idle",    0, 1, 'h44, 1, 0, 'h100, 0,            FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("c_dbusy",   0, 1, 'h44, 1, 0, 'h100, 0,            BUSY, 0,             S_DSERV,1, 1, 0,            0,            1, 0, 'h100, 0,            0));
    tbl.push_back(mk("c_dacc",    0, 1, 'h44, 1, 0, 'h100, 0,            ACC,  'h11223344,    S_DSERV,1, 0, 0,            'h11223344,   1, 0, 'h100, 0,            0));
    tbl.push_back(mk("c_gap",     0, 1, 'h44, 0, 0, 'h100, 0,            FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("c_ibusy",   0, 1, 'h44, 0, 0, 'h100, 0,            BUSY, 0,             S_ISERV,1, 1, 0,            0,            1, 0, 'h44,  0,            0));
    tbl.push_back(mk("c_iacc",    0, 1, 'h44, 0, 0, 'h100, 0,            ACC,  'h55,          S_ISERV,0, 1, 'h55,         0,            1, 0, 'h44,  0,            0));
    tbl.push_back(mk("s_idle",    0, 0, 0,    0, 1, 'h200, 'hDEADBEEF,   FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("s_busy",    0, 0, 0,    0, 1, 'h200, 'hDEADBEEF,   BUSY, 0,             S_DSERV,1, 1, 0,            0,            0, 1, 'h200, 'hDEADBEEF,   0));
    tbl.push_back(mk("s_acc",     0, 0, 0,    0, 1, 'h200, 'hDEADBEEF,   ACC,  'h12345678,    S_DSERV,1, 0, 0,            0,            0, 1, 'h200, 'hDEADBEEF,   0));
    tbl.push_back(mk("s_done",    0, 0, 0,    0, 0, 'h200, 'hDEADBEEF,   FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("b_idle",    0, 0, 0,    1, 1, 'h204, 'hCAFEF00D,   FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("b_acc",     0, 0, 0,    1, 1, 'h204, 'hCAFEF00D,   ACC,  'h99,          S_DSERV,1, 0, 0,            0,            0, 1, 'h204, 'hCAFEF00D,   0));
    tbl.push_back(mk("b_done",    0, 0, 0,    0, 0, 0,     0,            FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("w_idle",    0, 0, 0,    1, 0, 'h300, 0,            FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("w_busy",    0, 0, 0,    1, 0, 'h300, 0,            BUSY, 0,             S_DSERV,1, 1, 0,            0,            1, 0, 'h300, 0,            0));
    tbl.push_back(mk("w_drop",    0, 0, 0,    0, 0, 'h300, 0,            ACC,  'h77,          S_DSERV,1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("w_after",   0, 0, 0,    0, 0, 0,     0,            FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("e_idle",    0, 1, 'h80, 0, 0, 0,     0,            FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("e_err",     0, 1, 'h80, 0, 0, 0,     0,            ERR,  'hBAD,         S_ISERV,0, 1, 'hBAD,        0,            1, 0, 'h80,  0,            0));
    tbl.push_back(mk("e_sticky",  0, 0, 0,    1, 0, 'h310, 0,            FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            1));
    tbl.push_back(mk("e_dacc",    0, 0, 0,    1, 0, 'h310, 0,            ACC,  'h5,           S_DSERV,1, 0, 0,            'h5,          1, 0, 'h310, 0,            1));
    tbl.push_back(mk("e_rst",     1, 0, 0,    0, 0, 0,     0,            FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            1));
    tbl.push_back(mk("e_clr",     0, 0, 0,    0, 0, 0,     0,            FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("m_idle",    0, 0, 0,    1, 0, 'h400, 0,            FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("m_busy",    0, 0, 0,    1, 0, 'h400, 0,            BUSY, 0,             S_DSERV,1, 1, 0,            0,            1, 0, 'h400, 0,            0));
    tbl.push_back(mk("m_rst",     1, 0, 0,    1, 0, 'h400, 0,            BUSY, 0,             S_DSERV,1, 1, 0,            0,            1, 0, 'h400, 0,            0));
    tbl.push_back(mk("m_after",   0, 0, 0,    1, 0, 'h400, 0,            BUSY, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("m_wd",      0, 0, 0,    0, 0, 'h400, 0,            FREE, 0,             S_DSERV,1, 1, 0,            0,            0, 0, 0,     0,            0));
    tbl.push_back(mk("m_end",     0, 0, 0,    0, 0, 0,     0,            FREE, 0,             S_IDLE, 1, 1, 0,            0,            0, 0, 0,     0,            0));

    foreach (tbl[i]) apply(tbl[i]);

    // Timeout: RAM stuck BUSY, forced completion on the 8th service cycle with a zero load.
    apply(mk("t_idle", 0, 1, 'hC0, 0, 0, 0, 0, BUSY, 'hFFFF, S_IDLE, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 7; k++)
      apply(mk($sformatf("t_wait%0d", k), 0, 1, 'hC0, 0, 0, 0, 0, BUSY, 'hFFFF,
               S_ISERV, 1, 1, 0, 0, 1, 0, 'hC0, 0, 0));
    apply(mk("t_force", 0, 1, 'hC0, 0, 0, 0, 0, BUSY, 'hFFFF, S_ISERV, 0, 1, 0, 0, 1, 0, 'hC0, 0, 0));
    idle_vec("t_after", 0, 1);
    idle_vec("t_rst", 1, 1);
    idle_vec("t_clr", 0, 0);

`ifdef ARB_FAIRNESS_EN
    // Fetch held pending, data re-requesting: two data grants, one fetch grant, then data again.
    begin
      logic [1:0] exp_st[8];
      exp_st = '{S_IDLE, S_DSERV, S_IDLE, S_DSERV, S_IDLE, S_ISERV, S_IDLE, S_DSERV};
      for (int k = 0; k < 8; k++) begin
        if (exp_st[k] == S_DSERV)
          apply(mk($sformatf("fair%0d", k), 0, 1, 'hE0, 1, 0, 'h500, 0, ACC, 'h1,
                   S_DSERV, 1, 0, 0, 'h1, 1, 0, 'h500, 0, 0));
        else if (exp_st[k] == S_ISERV)
          apply(mk($sformatf("fair%0d", k), 0, 1, 'hE0, 1, 0, 'h500, 0, ACC, 'h1,
                   S_ISERV, 0, 1, 'h1, 0, 1, 0, 'hE0, 0, 0));
        else
          apply(mk($sformatf("fair%0d", k), 0, 1, 'hE0, 1, 0, 'h500, 0, ACC, 'h1,
                   S_IDLE, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
